// File: rtl/led_ctrl_pkg.sv
// Shared mode encodings and the mode-advance helper for the LED mode controller.
package led_ctrl_pkg;

    localparam int unsigned MODE_W = 2;

    localparam logic [MODE_W-1:0] ENC_OFF    = 2'd0;
    localparam logic [MODE_W-1:0] ENC_ON     = 2'd1;
    localparam logic [MODE_W-1:0] ENC_FOLLOW = 2'd2;
    localparam logic [MODE_W-1:0] ENC_BLINK  = 2'd3;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF    = ENC_OFF,
        MODE_ON     = ENC_ON,
        MODE_FOLLOW = ENC_FOLLOW,
        MODE_BLINK  = ENC_BLINK
    } mode_e;

    // Press order: OFF -> ON -> FOLLOW -> BLINK -> OFF
    function automatic mode_e next_mode(input mode_e cur);
        mode_e nxt;
        nxt = MODE_OFF;
        unique case (cur)
            MODE_OFF:    nxt = MODE_ON;
            MODE_ON:     nxt = MODE_FOLLOW;
            MODE_FOLLOW: nxt = MODE_BLINK;
            MODE_BLINK:  nxt = MODE_OFF;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/led_debounce.sv
// Two-flop synchronizer followed by an optional stability filter.
// Build option: define LED_MODE_CTRL_DEBOUNCE_EN to enable the counter-based
// debounce; otherwise the synchronized value is used directly.
module led_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic stable
);

    logic sync_meta;
    logic sync_q;

    // Bring the raw asynchronous input into the clock domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
        end else begin
            sync_meta <= din;
            sync_q    <= sync_meta;
        end
    end

`ifdef LED_MODE_CTRL_DEBOUNCE_EN
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] cnt;

    // Accept a new level only after it has persisted DEBOUNCE_CYCLES cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (sync_q == stable) begin
            cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            stable <= sync_q;
            cnt    <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end
`else
    // Zero-delay build: the synchronizer output is the stable value
    assign stable = sync_q;

    // DEBOUNCE_CYCLES has no effect here; an illegal zero setting still shows up as this empty block
    if (DEBOUNCE_CYCLES == 0) begin : g_debounce_range_guard
    end
`endif

endmodule

// File: rtl/led_mode_ctrl.sv
// Push-button cycled LED mode controller: OFF, ON, FOLLOW (switch), BLINK.
// Build option: LED_MODE_CTRL_DEBOUNCE_EN enables input debouncing in led_debounce.
module led_mode_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = 1_000_000,
    parameter int unsigned BLINK_HALF_CYCLES = 50_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              switch,
    input  logic              btn,
    output logic              led,
    output logic [MODE_W-1:0] mode
);

    localparam int unsigned BW = (BLINK_HALF_CYCLES > 1) ? $clog2(BLINK_HALF_CYCLES) : 1;

    logic          sw_stable;
    logic          btn_stable;
    logic          btn_prev;
    logic          press_c;
    mode_e         state;
    mode_e         state_next;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;
    logic          blink_tc_c;
    logic          led_next;

    led_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sw_db (
        .clk    (clk),
        .rst    (rst),
        .din    (switch),
        .stable (sw_stable)
    );

    led_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_db (
        .clk    (clk),
        .rst    (rst),
        .din    (btn),
        .stable (btn_stable)
    );

    // Remember last stable button level for rising-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_prev <= 1'b0;
        end else begin
            btn_prev <= btn_stable;
        end
    end

    assign press_c = btn_stable & ~btn_prev;

    // Mode state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= MODE_OFF;
        end else begin
            state <= state_next;
        end
    end

    // Advance one mode per press pulse, otherwise hold
    always_comb begin
        state_next = state;
        if (press_c) begin
            state_next = next_mode(state);
        end
    end

    assign mode = state;

    assign blink_tc_c = (blink_cnt == BW'(BLINK_HALF_CYCLES - 1));

    // Blink timer runs only while staying in BLINK; entry, exit and idle park it at 0 / phase 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if ((state_next != MODE_BLINK) || (state != MODE_BLINK)) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (blink_tc_c) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

    // LED source selected by the current mode
    always_comb begin
        led_next = 1'b0;
        unique case (state)
            MODE_OFF:    led_next = 1'b0;
            MODE_ON:     led_next = 1'b1;
            MODE_FOLLOW: led_next = sw_stable;
            MODE_BLINK:  led_next = blink_phase;
        endcase
    end

    // Registered LED drive, one cycle behind its source
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led <= 1'b0;
        end else begin
            led <= led_next;
        end
    end

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Scoreboard bench for led_mode_ctrl with a behavioural reference model.
// Follows the LED_MODE_CTRL_DEBOUNCE_EN setting of the build.
module tb_led_mode_ctrl;

    localparam int unsigned DBC = 4;
    localparam int unsigned HALF = 3;
`ifdef LED_MODE_CTRL_DEBOUNCE_EN
    localparam int MODEL_DB = 4;
`else
    localparam int MODEL_DB = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       switch;
    logic       btn;
    logic       led;
    logic [1:0] mode;
    logic       probe;

    led_mode_ctrl #(
        .DEBOUNCE_CYCLES   (DBC),
        .BLINK_HALF_CYCLES (HALF)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .switch (switch),
        .btn    (btn),
        .led    (led),
        .mode   (mode)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       led;
        logic [1:0] mode;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state: index 0 = switch, 1 = btn
    logic raw_d [2];
    logic syn   [2];
    logic st    [2];
    int   run   [2];
    logic btn_st_d;
    int   m_mode;
    int   m_age;
    logic m_led;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: levels filtered by persistence, mode counts press edges, blink from time since entry
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                raw_d[i] = 1'b0; syn[i] = 1'b0; st[i] = 1'b0; run[i] = 0;
            end
            btn_st_d = 1'b0;
            m_mode   = 0;
            m_age    = 0;
            m_led    = 1'b0;
            exp_q.delete();
        end else begin
            logic press;
            int   mode_n;
            logic now_raw [2];
            now_raw[0] = switch;
            now_raw[1] = btn;
            case (m_mode)
                0:       m_led = 1'b0;
                1:       m_led = 1'b1;
                2:       m_led = st[0];
                default: m_led = (((m_age / HALF) % 2) == 0);
            endcase
            press  = st[1] && !btn_st_d;
            mode_n = press ? (m_mode + 1) % 4 : m_mode;
            if (mode_n == 3) m_age = (m_mode == 3) ? m_age + 1 : 0;
            else             m_age = 0;
            m_mode   = mode_n;
            btn_st_d = st[1];
            for (int i = 0; i < 2; i++) begin
                logic syn_old;
                syn_old  = syn[i];
                syn[i]   = raw_d[i];
                raw_d[i] = now_raw[i];
                if (MODEL_DB == 0) begin
                    st[i] = syn[i];
                end else if (syn_old != st[i]) begin
                    run[i]++;
                    if (run[i] == MODEL_DB) begin
                        st[i]  = syn_old;
                        run[i] = 0;
                    end
                end else begin
                    run[i] = 0;
                end
            end
            exp_q.push_back('{led: m_led, mode: 2'(m_mode)});
        end
    end

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
    endtask

    // Monitor: compare every output cycle against the scoreboard; probe checks asynchronous reset
    initial begin
        forever begin
            @(negedge clk or posedge probe);
            if (probe) begin
                chk("rst_led", int'(led), 0);
                chk("rst_mode", int'(mode), 0);
            end else if (!rst && exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("led", int'(led), int'(e.led));
                chk("mode", int'(mode), int'(e.mode));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int hold, input int gap);
        btn = 1'b1;
        idle(hold);
        btn = 1'b0;
        idle(gap);
    endtask

    task automatic goto_mode(input int target);
        for (int k = 0; k < 5 && m_mode != target; k++) press(6, 8);
    endtask

    // Asynchronous reset away from the clock edge, checked before any edge
    task automatic do_reset();
        @(negedge clk);
        #1 rst = 1'b1;
        #1 probe = 1'b1;
        #1 probe = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; switch = 1'b0; btn = 1'b0; probe = 1'b0;
        idle(2);
        #1 probe = 1'b1;
        #1 probe = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        idle(3);

        // Clean presses through all four modes
        repeat (4) press(10, 10);

        // Short glitch then a valid press
        press(3, 10);
        press(8, 10);

        // FOLLOW tracks the switch
        goto_mode(2);
        switch = 1'b1; idle(12);
        switch = 1'b0; idle(12);
        switch = 1'b1; idle(2); switch = 1'b0; idle(10);

        // Switch changes in ON leave LED lit
        goto_mode(1);
        switch = 1'b1; idle(10);
        switch = 1'b0; idle(10);

        // Blink pattern and presses at every blink offset (one hits terminal count)
        for (int off = 0; off < 7; off++) begin
            goto_mode(3);
            idle(off);
            press(6, 12);
        end

        // Reset in the middle of BLINK
        goto_mode(3);
        idle(4);
        do_reset();
        idle(10);

        // Reset during an in-progress debounce
        btn = 1'b1; idle(2);
        do_reset();
        btn = 1'b0;
        idle(10);

        // Randomized input activity
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(7, 0) == 0) btn = ~btn;
            if ($urandom_range(15, 0) == 0) switch = ~switch;
            if ($urandom_range(999, 0) == 0) begin
                btn = 1'b0;
                do_reset();
            end
        end
        btn = 1'b0;
        idle(20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
